// File: rtl/std_mem_stream_pkg.sv
// ============================================================================
//  Module      : std_mem_stream_pkg
//  Description : Shared state encoding and constants for the 1-D memory
//                stream controllers (writer today, matching reader later).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package std_mem_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FIN    = 3'd4
    } stream_state_t;

    // Cycles a controller may sit waiting for mem_done before it is flagged.
    localparam int unsigned c_wait_timeout = 64;

endpackage

`default_nettype wire

// File: rtl/std_mem_addr_wrap.sv
// ============================================================================
//  Module      : std_mem_addr_wrap
//  Description : Address register with load and modulo-SIZE increment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_mem_addr_wrap #(
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [IDX_SIZE-1:0] i_base,
    input  logic                i_inc,
    output logic [IDX_SIZE-1:0] o_addr
);

    logic [IDX_SIZE-1:0] r_addr;

    // Wrap at SIZE-1 rather than at the natural 2^IDX_SIZE rollover.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
        end else if (i_inc) begin
            if (r_addr == IDX_SIZE'(SIZE - 1))
                r_addr <= '0;
            else
                r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/std_mem_d1_stream_writer.sv
// ============================================================================
//  Module      : std_mem_d1_stream_writer
//  Description : go/done controller that writes len words from a valid/ready
//                stream into a std_mem_d1 at consecutive (wrapping) addresses.
//                Optional simulation checks: define CALYX_MEM_STREAM_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_mem_d1_stream_writer #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 16,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] base,
    input  logic [IDX_SIZE:0]   len,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    in_data,
    output logic                in_ready,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic [WIDTH-1:0]    mem_write_data,
    output logic                mem_write_en,
    input  logic                mem_done,
    output logic [IDX_SIZE:0]   count,
    output logic                done
);

    import std_mem_stream_pkg::*;

    stream_state_t       r_state;
    stream_state_t       w_next;
    logic [IDX_SIZE:0]   r_len;
    logic [IDX_SIZE:0]   r_count;
    logic [WIDTH-1:0]    r_data;
    logic                w_load;
    logic                w_inc;
    logic                w_last;

    assign w_last = ((r_count + (IDX_SIZE+1)'(1)) == r_len);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (go) begin
                    w_load = 1'b1;
                    w_next = (len == '0) ? ST_FIN : ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (in_valid)
                    w_next = ST_WRITE;
            end
            ST_WRITE: w_next = ST_WAIT;
            // Only WAIT consumes mem_done; a pulse coincident with the strobe is dropped.
            ST_WAIT: begin
                if (mem_done) begin
                    w_inc  = 1'b1;
                    w_next = w_last ? ST_FIN : ST_ACCEPT;
                end
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len   <= '0;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            if (w_load) begin
                r_len   <= len;
                r_count <= '0;
            end
            if (r_state == ST_ACCEPT && in_valid)
                r_data <= in_data;
            if (w_inc)
                r_count <= r_count + 1'b1;
        end
    end

    std_mem_addr_wrap #(
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) u_addr (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_base (base),
        .i_inc  (w_inc),
        .o_addr (mem_addr0)
    );

    assign in_ready       = (r_state == ST_ACCEPT);
    assign mem_write_en   = (r_state == ST_WRITE);
    assign mem_write_data = r_data;
    assign count          = r_count;
    assign done           = (r_state == ST_FIN);

`ifdef CALYX_MEM_STREAM_CHECK_EN
    logic [WIDTH-1:0] r_chk_data;
    logic             r_chk_stall;
    logic [6:0]       r_chk_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chk_data  <= '0;
            r_chk_stall <= 1'b0;
            r_chk_wait  <= '0;
        end else begin
            r_chk_data  <= in_data;
            r_chk_stall <= in_valid && !in_ready;
            if (r_chk_stall && in_valid && (in_data != r_chk_data))
                $error("std_mem_d1_stream_writer: in_data changed while stalled");
            if (mem_done && (r_state != ST_WRITE) && (r_state != ST_WAIT))
                $error("std_mem_d1_stream_writer: mem_done outside WRITE/WAIT");
            if (r_state == ST_WAIT) begin
                if (r_chk_wait != 7'h7f)
                    r_chk_wait <= r_chk_wait + 1'b1;
                if (r_chk_wait == 7'(c_wait_timeout))
                    $error("std_mem_d1_stream_writer: WAIT exceeded timeout");
            end else begin
                r_chk_wait <= '0;
            end
            if (int'(mem_addr0) >= SIZE)
                $error("std_mem_d1_stream_writer: mem_addr0 out of range");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_std_mem_d1_stream_writer.sv
// ============================================================================
//  Module      : tb_std_mem_d1_stream_writer
//  Description : Scoreboard bench with a behavioural memory and producer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_std_mem_d1_stream_writer;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 16;
    localparam int IDX_SIZE = 4;

    logic                clk;
    logic                reset;
    logic                go;
    logic [IDX_SIZE-1:0] base;
    logic [IDX_SIZE:0]   len;
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic [WIDTH-1:0]    mem_write_data;
    logic                mem_write_en;
    logic                mem_done;
    logic [IDX_SIZE:0]   count;
    logic                done;

    std_mem_d1_stream_writer #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .base           (base),
        .len            (len),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .mem_addr0      (mem_addr0),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_done       (mem_done),
        .count          (count),
        .done           (done)
    );

    typedef struct { logic [IDX_SIZE-1:0] addr; logic [WIDTH-1:0] data; } wr_t;
    typedef struct { logic [WIDTH-1:0] data; int gap; } word_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [WIDTH-1:0] mem     [SIZE];
    logic [WIDTH-1:0] ref_mem [SIZE];
    wr_t        exp_wr[$];
    int         exp_done[$];
    word_t      prod_q[$];
    bit         flush_req = 0;
    int         mem_lat_max = 0;
    bit         ready_seen, done_seen;
    int         first_ready_cyc, done_cyc, go_cyc, wr_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural std_mem_d1: write on strobe, done one cycle later (+ random extra latency).
    initial begin
        int lat;
        mem_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && mem_write_en) begin
                mem[mem_addr0] = mem_write_data;
                lat = $urandom_range(mem_lat_max);
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1;
                if (!reset) mem_done = 1'b1;
                @(posedge clk);
                #1 mem_done = 1'b0;
            end
        end
    end

    // Producer: presents queued words, honouring per-word idle gaps.
    initial begin
        bit hs;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (flush_req) begin
                prod_q.delete();
                in_valid  = 1'b0;
                flush_req = 0;
                continue;
            end
            if (hs) begin
                void'(prod_q.pop_front());
                in_valid = 1'b0;
            end
            if (!in_valid && prod_q.size() > 0) begin
                if (prod_q[0].gap > 0)
                    prod_q[0].gap = prod_q[0].gap - 1;
                else begin
                    in_valid = 1'b1;
                    in_data  = prod_q[0].data;
                end
            end
            if (!in_valid) in_data = $urandom;
        end
    end

    // Monitor: pops the scoreboard on every write strobe and done pulse.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (in_ready && !ready_seen) begin
                    ready_seen      = 1;
                    first_ready_cyc = cyc;
                end
                if (mem_write_en) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", mem_addr0, w.addr);
                        chk("wr_data", mem_write_data, w.data);
                    end
                end
                if (done) begin
                    done_seen = 1;
                    done_cyc  = cyc;
                    if (exp_done.size() == 0)
                        chk("unexpected_done", 1, 0);
                    else
                        chk("done_count", count, exp_done.pop_front());
                end
            end
        end
    end

    task automatic start_xfer(input int b, input int l, input int maxgap,
                              input bit fixed_data, input int stall_idx, input int keep);
        logic [WIDTH-1:0] d;
        int a;
        ready_seen = 0;
        done_seen  = 0;
        wr_seen    = 0;
        for (int i = 0; i < l; i++) begin
            d = fixed_data ? WIDTH'(32'hA0 + i) : WIDTH'($urandom);
            a = (b + i) % SIZE;
            prod_q.push_back('{d, (i == 0) ? 0 : ((i == stall_idx) ? 5 : int'($urandom_range(maxgap)))});
            exp_wr.push_back('{IDX_SIZE'(a), d});
            if (i < keep) ref_mem[a] = d;
        end
        @(posedge clk);
        #1;
        base = IDX_SIZE'(b);
        len  = (IDX_SIZE+1)'(l);
        go   = 1'b1;
        @(posedge clk);
        #1;
        go     = 1'b0;
        go_cyc = cyc;
        base   = IDX_SIZE'($urandom);
        len    = (IDX_SIZE+1)'($urandom);
    endtask

    task automatic run_xfer(input int b, input int l, input int maxgap,
                            input bit fixed_data, input int stall_idx);
        int t;
        exp_done.push_back(l);
        start_xfer(b, l, maxgap, fixed_data, stall_idx, l);
        t = 0;
        while (!done_seen && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("done_within_budget", done_seen, 1);
        chk("write_strobes", wr_seen, l);
        @(negedge clk);
        chk("count_held", count, l);
    endtask

    initial begin
        int t;
        for (int i = 0; i < SIZE; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1;
        go    = 1'b0;
        base  = '0;
        len   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_write_en", mem_write_en, 0);
        chk("rst_addr", mem_addr0, 0);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Always-valid producer, base 0: 3 cycles per word.
        mem_lat_max = 0;
        run_xfer(0, 4, 0, 1, -1);
        chk("ready_after_go", first_ready_cyc, go_cyc);
        chk("done_latency", done_cyc - first_ready_cyc, 12);
        for (int i = 0; i < 4; i++) chk("mem_directed", mem[i], 32'hA0 + i);

        // Address wrap 14,15,0,1.
        run_xfer(14, 4, 0, 0, -1);

        // Zero-length transfer.
        run_xfer(3, 0, 0, 0, -1);
        chk("len0_done_latency", done_cyc, go_cyc);
        chk("len0_no_ready", ready_seen, 0);

        // Five-cycle producer stall before the second word.
        run_xfer(6, 4, 0, 0, 1);

        // Reset during WAIT of word 2.
        start_xfer(5, 4, 0, 0, -1, 2);
        t = 0;
        while (wr_seen < 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("reset_reach_wait", wr_seen, 2);
        #1;
        reset     = 1'b1;
        flush_req = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_wr.delete();
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_write_en", mem_write_en, 0);
        chk("mid_rst_addr", mem_addr0, 0);
        chk("mid_rst_wdata", mem_write_data, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_done", done, 0);
        repeat (3) @(posedge clk);
        chk("kept_word0", mem[5], ref_mem[5]);
        chk("kept_word1", mem[6], ref_mem[6]);
        run_xfer(9, 3, 0, 0, -1);

        // Randomized transfers with producer gaps and memory latency.
        mem_lat_max = 2;
        for (int k = 0; k < 10; k++)
            run_xfer(int'($urandom_range(SIZE - 1)), int'($urandom_range(20)), 3, 0, -1);

        repeat (5) @(posedge clk);
        chk("writes_drained", exp_wr.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        for (int i = 0; i < SIZE; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
